// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared register-file geometry for the writeback scheduler.
package regfile_wb_scheduler_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// regfile_scoreboard: pending-write bitmap and outstanding count for long-unit destinations.
//   set_en/set_wa : a long op issued (count always bumps, bit set only for wa!=0)
//   clr_en/clr_wa : a long result drained to the register file
//   rs/rt/wa      : issue-side lookup addresses -> rs_pend/rt_pend/wa_pend
//   full          : MAX_LONG ops already outstanding
//   cnt/pending   : raw state, exported for checking
module regfile_scoreboard
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int MAX_LONG = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_wa,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_wa,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] wa,
    output logic                  rs_pend,
    output logic                  rt_pend,
    output logic                  wa_pend,
    output logic                  full,
    output logic [CNT_W-1:0]      cnt,
    output logic [NUM_REGS-1:0]   pending
);
    logic [NUM_REGS-1:0] pend_nxt;

    // Set after clear: the two addresses never coincide because WAW blocks issue to a pending register.
    always_comb begin
        pend_nxt = pending;
        if (clr_en) pend_nxt[clr_wa] = 1'b0;
        if (set_en) pend_nxt[set_wa] = 1'b1;
        pend_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            cnt <= '0;
        end else begin
            pending <= pend_nxt;
            cnt <= cnt + CNT_W'(set_en) - CNT_W'(clr_en);
        end
    end

    always_comb begin
        rs_pend = pending[rs];
        rt_pend = pending[rt];
        wa_pend = pending[wa];
        full = cnt == CNT_W'(MAX_LONG);
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between pipeline writeback and a long unit.
//   issue_*          : decode-side instruction; issue_stall holds decode on RAW/WAW/capacity hazards
//   pipe_we/wa/wd    : pipeline writeback, fixed priority on the write port
//   long_valid/wa/wd : long-unit result offer; long_ready accepts into a one-entry buffer
//   rf_we/wa/wd      : register file write port
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int MAX_LONG = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_uses_rs,
    input  logic                  issue_uses_rt,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_wa,
    input  logic                  issue_long,
    output logic                  issue_stall,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0]     pipe_wd,
    input  logic                  long_valid,
    input  logic [REG_ADDR_W-1:0] long_wa,
    input  logic [DATA_W-1:0]     long_wd,
    output logic                  long_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_wd
);
    logic                  buf_v;
    logic [REG_ADDR_W-1:0] buf_wa;
    logic [DATA_W-1:0]     buf_wd;
    logic                  pipe_act;
    logic                  drain;
    logic                  set_en;
    logic                  rs_pend;
    logic                  rt_pend;
    logic                  wa_pend;
    logic                  full;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_REGS-1:0]   pending;

    regfile_scoreboard #(.MAX_LONG(MAX_LONG), .CNT_W(CNT_W)) u_sb (
        .clk(clk),
        .rst_n(rst_n),
        .set_en(set_en),
        .set_wa(issue_wa),
        .clr_en(drain),
        .clr_wa(buf_wa),
        .rs(issue_rs),
        .rt(issue_rt),
        .wa(issue_wa),
        .rs_pend(rs_pend),
        .rt_pend(rt_pend),
        .wa_pend(wa_pend),
        .full(full),
        .cnt(cnt),
        .pending(pending)
    );

    // A pipeline write to $0 leaves the port free for a drain; reset also silences the port.
    always_comb begin
        long_ready = !buf_v;
        pipe_act = rst_n && pipe_we && pipe_wa != ZERO_REG;
        drain = buf_v && !pipe_act;
        rf_we = pipe_act || (drain && buf_wa != ZERO_REG);
        rf_wa = pipe_act ? pipe_wa : drain ? buf_wa : ZERO_REG;
        rf_wd = pipe_act ? pipe_wd : drain ? buf_wd : '0;
        issue_stall = issue_valid && ((issue_uses_rs && rs_pend) || (issue_uses_rt && rt_pend)
                      || (issue_we && wa_pend) || (issue_we && issue_long && full));
        set_en = issue_valid && !issue_stall && issue_we && issue_long;
    end

    // Accept requires an empty buffer, so accept and drain never share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v <= 1'b0;
            buf_wa <= ZERO_REG;
            buf_wd <= '0;
        end else if (long_valid && long_ready) begin
            buf_v <= 1'b1;
            buf_wa <= long_wa;
            buf_wd <= long_wd;
        end else if (drain) begin
            buf_v <= 1'b0;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(drain && cnt == '0));
    assert property (@(posedge clk) disable iff (!rst_n) !(long_valid && long_wa != ZERO_REG && !pending[long_wa]));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: randomized scoreboard bench with a queue-based reference model.
module tb_regfile_wb_scheduler;
    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_uses_rs;
    logic        issue_uses_rt;
    logic        issue_we;
    logic [4:0]  issue_wa;
    logic        issue_long;
    logic        issue_stall;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        long_valid;
    logic [4:0]  long_wa;
    logic [31:0] long_wd;
    logic        long_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int tests = 0;
    int fails = 0;
    int lu_rate = 50;
    logic lu_hold = 1'b0;

    bit [31:0]  mpend = '0;
    int         mcnt = 0;
    wr_t        mbuf[$];
    wr_t        exp_q[$];
    logic [4:0] lu_q[$];

    regfile_wb_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .issue_valid(issue_valid),
        .issue_rs(issue_rs),
        .issue_rt(issue_rt),
        .issue_uses_rs(issue_uses_rs),
        .issue_uses_rt(issue_uses_rt),
        .issue_we(issue_we),
        .issue_wa(issue_wa),
        .issue_long(issue_long),
        .issue_stall(issue_stall),
        .pipe_we(pipe_we),
        .pipe_wa(pipe_wa),
        .pipe_wd(pipe_wd),
        .long_valid(long_valid),
        .long_wa(long_wa),
        .long_wd(long_wd),
        .long_ready(long_ready),
        .rf_we(rf_we),
        .rf_wa(rf_wa),
        .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        #2;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(rf_wa), 32'hffff_ffff);
            end else begin
                check("rf_wa", 32'(rf_wa), 32'(exp_q[0].wa));
                check("rf_wd", rf_wd, exp_q[0].wd);
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() != 0) begin
            check("missing_write", 32'(rf_we), 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic rand_inputs();
        issue_valid = $urandom_range(0, 3) != 0;
        issue_rs = 5'($urandom_range(0, 7));
        issue_rt = 5'($urandom_range(0, 7));
        issue_wa = 5'($urandom_range(0, 7));
        issue_uses_rs = 1'($urandom);
        issue_uses_rt = 1'($urandom);
        issue_we = $urandom_range(0, 3) != 0;
        issue_long = 1'($urandom);
        pipe_we = $urandom_range(0, 2) == 0;
        pipe_wa = 5'($urandom_range(0, 7));
        pipe_wd = $urandom;
    endtask

    task automatic set_issue(input logic v, input logic urs, input logic [4:0] rs,
                             input logic we, input logic lng, input logic [4:0] wa);
        issue_valid = v;
        issue_uses_rs = urs;
        issue_rs = rs;
        issue_uses_rt = 1'b0;
        issue_rt = 5'd0;
        issue_we = we;
        issue_long = lng;
        issue_wa = wa;
    endtask

    // One clock of stimulus and model: called at a negedge, returns at the next negedge.
    task automatic step();
        wr_t  e;
        logic exp_ready, exp_stall, pipe_act, drain, acc, fire;
        if (lu_q.size() != 0 && (lu_hold || $urandom_range(0, 99) < lu_rate)) begin
            long_valid = 1'b1;
            long_wa = lu_q[0];
            if (!lu_hold) long_wd = $urandom;
        end else begin
            long_valid = 1'b0;
        end
        #1;
        exp_ready = mbuf.size() == 0;
        exp_stall = issue_valid && ((issue_uses_rs && mpend[issue_rs]) || (issue_uses_rt && mpend[issue_rt])
                    || (issue_we && mpend[issue_wa]) || (issue_we && issue_long && mcnt == 4));
        check("long_ready", 32'(long_ready), 32'(exp_ready));
        check("issue_stall", 32'(issue_stall), 32'(exp_stall));
        pipe_act = pipe_we && pipe_wa != 5'd0;
        drain = !pipe_act && mbuf.size() != 0;
        if (pipe_act) begin
            e.wa = pipe_wa;
            e.wd = pipe_wd;
            exp_q.push_back(e);
        end else if (drain && mbuf[0].wa != 5'd0) begin
            exp_q.push_back(mbuf[0]);
        end
        acc = long_valid && exp_ready;
        fire = issue_valid && !exp_stall;
        @(posedge clk);
        if (drain) begin
            mpend[mbuf[0].wa] = 1'b0;
            mcnt--;
            void'(mbuf.pop_front());
        end
        if (acc) begin
            e.wa = long_wa;
            e.wd = long_wd;
            mbuf.push_back(e);
            void'(lu_q.pop_front());
            lu_hold = 1'b0;
        end else begin
            lu_hold = long_valid;
        end
        if (fire && issue_we && issue_long) begin
            if (issue_wa != 5'd0) mpend[issue_wa] = 1'b1;
            mcnt++;
            lu_q.push_back(issue_wa);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_issue(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        pipe_we = 1'b0;
        pipe_wa = 5'd0;
        pipe_wd = '0;
        long_valid = 1'b0;
        long_wa = 5'd0;
        long_wd = '0;
        #3;
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_long_ready", 32'(long_ready), 32'd1);
        #4 rst_n = 1'b1;
        @(negedge clk);

        // RAW on a long destination, released by the drain.
        lu_rate = 0;
        set_issue(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8);
        step();
        set_issue(1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0);
        step();
        step();
        lu_rate = 100;
        for (int i = 0; i < 4; i++) step();

        // Capacity: four outstanding, the fifth waits for a drain.
        lu_rate = 0;
        for (int i = 1; i <= 4; i++) begin
            set_issue(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'(i));
            step();
        end
        set_issue(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5);
        step();
        step();
        lu_rate = 100;
        for (int i = 0; i < 4; i++) step();
        set_issue(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic.
        lu_rate = 50;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        set_issue(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        pipe_we = 1'b0;
        lu_rate = 100;
        for (int i = 0; i < 40; i++) step();

        // Mid-operation reset with a buffered result and a pending register.
        lu_rate = 0;
        set_issue(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5);
        step();
        set_issue(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        pipe_we = 1'b1;
        pipe_wa = 5'd4;
        lu_rate = 100;
        for (int i = 0; i < 20 && mbuf.size() == 0; i++) step();
        check("buffer_filled", 32'(mbuf.size()), 32'd1);
        rst_n = 1'b0;
        set_issue(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5);
        #1;
        check("midreset_rf_we", 32'(rf_we), 32'd0);
        check("midreset_long_ready", 32'(long_ready), 32'd1);
        check("midreset_stall", 32'(issue_stall), 32'd0);
        mpend = '0;
        mcnt = 0;
        mbuf.delete();
        exp_q.delete();
        lu_q.delete();
        lu_hold = 1'b0;
        long_valid = 1'b0;
        pipe_we = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        step();
        lu_rate = 50;
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            step();
        end
        set_issue(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        pipe_we = 1'b0;
        lu_rate = 100;
        for (int i = 0; i < 40; i++) step();
        check("model_drained", 32'(mcnt), 32'd0);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
